// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, round constants and GF(2^8) helpers
// used by the inverse-cipher datapath and its S-box modules.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ROUND0,
        ROUNDS,
        ROUND_LAST
    } aes_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        return gmul(x127, x127);
    endfunction

    // Round constant for key-expansion step i (1..10), placed in the top byte
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Row r of the state rotates right by r columns; byte n sits at bits [127-8n -: 8]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    // One column through the InvMixColumns matrix (0e 0b 0d 09 circulant)
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by GF(2^8) inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] affVal;

    // Undo the affine map (rotl1 ^ rotl3 ^ rotl6 ^ 0x05), then invert
    always_comb begin
        affVal = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]}
               ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
        out_o  = gf_inv(affVal);
    end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] invVal;

    // Inverse then affine map b ^ rotl1..4(b) ^ 0x63
    always_comb begin
        invVal = gf_inv(in_i);
        out_o  = invVal ^ {invVal[6:0], invVal[7]} ^ {invVal[5:0], invVal[7:6]}
               ^ {invVal[4:0], invVal[7:5]} ^ {invVal[3:0], invVal[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryptor: expands the key into an 11-entry round-key
// store, then applies one inverse round per clock, pulsing valid_out at the end.
module aes_inv_cipher_top
    import aes_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_in,
    input  logic [31:0] ciphertext0_in,
    input  logic [31:0] ciphertext1_in,
    input  logic [31:0] ciphertext2_in,
    input  logic [31:0] ciphertext3_in,
    input  logic [31:0] key0_in,
    input  logic [31:0] key1_in,
    input  logic [31:0] key2_in,
    input  logic [31:0] key3_in,
    output logic [31:0] plaintext0_out,
    output logic [31:0] plaintext1_out,
    output logic [31:0] plaintext2_out,
    output logic [31:0] plaintext3_out,
    output logic        valid_out,
    output logic        busy_out
);

    aes_state_e   fsmQ, fsmD;
    logic [3:0]   cntQ, cntD;
    logic [3:0]   rndQ, rndD;
    logic [127:0] ctQ, ctD;
    logic [127:0] blkQ, blkD;
    logic [127:0] ptQ, ptD;
    logic         validQ, validD;
    logic         busyQ, busyD;
    logic [127:0] rkQ [0:NR];

    logic [127:0] shifted, subbed, roundOut, lastOut;
    logic [127:0] prevKey, keyStep;
    logic [31:0]  rotWord, subWord, tempWord;

    // State path: InvShiftRows feeding sixteen inverse S-boxes
    assign shifted = inv_shift_rows(blkQ);
    for (genvar b = 0; b < 16; b++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (
            .in_i  (shifted[127 - 8*b -: 8]),
            .out_o (subbed[127 - 8*b -: 8])
        );
    end

    // Middle rounds add the key before InvMixColumns; the last round skips it
    always_comb begin
        roundOut = '0;
        for (int c = 0; c < 4; c++) begin
            roundOut[127 - 32*c -: 32] = inv_mix_column(subbed[127 - 32*c -: 32] ^ rkQ[rndQ][127 - 32*c -: 32]);
        end
        lastOut = subbed ^ rkQ[0];
    end

    // Key path: RotWord of the previous round key's last word through four forward S-boxes
    assign prevKey = rkQ[cntQ - 4'd1];
    assign rotWord = {prevKey[23:0], prevKey[31:24]};
    for (genvar w = 0; w < NK; w++) begin : g_fwd_sbox
        aes_sbox u_sbox (
            .in_i  (rotWord[31 - 8*w -: 8]),
            .out_o (subWord[31 - 8*w -: 8])
        );
    end

    // Chain the four words of the next round key
    always_comb begin
        tempWord          = subWord ^ {rcon(cntQ), 24'h000000};
        keyStep[127:96]   = prevKey[127:96] ^ tempWord;
        keyStep[95:64]    = prevKey[95:64]  ^ keyStep[127:96];
        keyStep[63:32]    = prevKey[63:32]  ^ keyStep[95:64];
        keyStep[31:0]     = prevKey[31:0]   ^ keyStep[63:32];
    end

    // Round-key store survives reset; it is always rebuilt before use
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fsmQ == IDLE && start_in)
                rkQ[0] <= {key0_in, key1_in, key2_in, key3_in};
            else if (fsmQ == KEYEXP)
                rkQ[cntQ] <= keyStep;
        end
    end

    // State register and all control/datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsmQ   <= IDLE;
            cntQ   <= '0;
            rndQ   <= '0;
            ctQ    <= '0;
            blkQ   <= '0;
            ptQ    <= '0;
            validQ <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            fsmQ   <= fsmD;
            cntQ   <= cntD;
            rndQ   <= rndD;
            ctQ    <= ctD;
            blkQ   <= blkD;
            ptQ    <= ptD;
            validQ <= validD;
            busyQ  <= busyD;
        end
    end

    // Next-state sequencing: key expansion, initial add, nine rounds, final round
    always_comb begin
        fsmD = fsmQ;
        case (fsmQ)
            IDLE:       if (start_in) fsmD = KEYEXP;
            KEYEXP:     if (cntQ == 4'(NR)) fsmD = ROUND0;
            ROUND0:     fsmD = ROUNDS;
            ROUNDS:     if (rndQ == 4'd1) fsmD = ROUND_LAST;
            ROUND_LAST: fsmD = IDLE;
            default:    fsmD = IDLE;
        endcase
    end

    // Per-state datapath and output updates
    always_comb begin
        cntD   = cntQ;
        rndD   = rndQ;
        ctD    = ctQ;
        blkD   = blkQ;
        ptD    = ptQ;
        validD = 1'b0;
        busyD  = busyQ;
        case (fsmQ)
            IDLE: begin
                if (start_in) begin
                    ctD   = {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in};
                    cntD  = 4'd1;
                    busyD = 1'b1;
                end
            end
            KEYEXP: cntD = cntQ + 4'd1;
            ROUND0: begin
                blkD = ctQ ^ rkQ[NR];
                rndD = 4'd9;
            end
            ROUNDS: begin
                blkD = roundOut;
                rndD = rndQ - 4'd1;
            end
            ROUND_LAST: begin
                ptD    = lastOut;
                validD = 1'b1;
                busyD  = 1'b0;
            end
            default: ;
        endcase
    end

    assign {plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out} = ptQ;
    assign valid_out = validQ;
    assign busy_out  = busyQ;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Testbench for aes_inv_cipher_top: known-answer vectors, latency, ignored
// restart, mid-operation reset and back-to-back operation.
module tb_aes_inv_cipher_top;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] CT2  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] PT2  = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] KEY3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int LATENCY = 22;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] ciphertext0_in = '0, ciphertext1_in = '0, ciphertext2_in = '0, ciphertext3_in = '0;
    logic [31:0] key0_in = '0, key1_in = '0, key2_in = '0, key3_in = '0;
    logic [31:0] plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out;
    logic        valid_out, busy_out;

    int testsRun = 0;
    int testsFailed = 0;
    int validSeen = 0;
    logic [127:0] expQ [$];

    aes_inv_cipher_top dut (
        .CLK            (CLK),
        .RST            (RST),
        .start_in       (start_in),
        .ciphertext0_in (ciphertext0_in),
        .ciphertext1_in (ciphertext1_in),
        .ciphertext2_in (ciphertext2_in),
        .ciphertext3_in (ciphertext3_in),
        .key0_in        (key0_in),
        .key1_in        (key1_in),
        .key2_in        (key2_in),
        .key3_in        (key3_in),
        .plaintext0_out (plaintext0_out),
        .plaintext1_out (plaintext1_out),
        .plaintext2_out (plaintext2_out),
        .plaintext3_out (plaintext3_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Running count of valid pulses, used to prove that aborted or ignored blocks never complete
    always @(posedge CLK) begin
        if (valid_out === 1'b1) validSeen++;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual running, required done)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [127:0] ptOut();
        return {plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out};
    endfunction

    // Called at a negedge: drive one start pulse; optionally queue its expected plaintext
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key,
                                 input logic [127:0] expPt, input bit push);
        {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in} = ct;
        {key0_in, key1_in, key2_in, key3_in} = key;
        start_in = 1'b1;
        if (push) expQ.push_back(expPt);
        @(negedge CLK);
        start_in = 1'b0;
    endtask

    // Step negedges until valid_out; lat counts cycles since the acceptance edge
    task automatic waitForValid(input int startLat, output int lat,
                                output bit timedOut, output bit busyDropped);
        lat = startLat;
        busyDropped = 1'b0;
        while (valid_out !== 1'b1 && lat < 60) begin
            if (busy_out !== 1'b1) busyDropped = 1'b1;
            @(negedge CLK);
            lat++;
        end
        timedOut = (valid_out !== 1'b1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        testsRun++;
        if (ptOut() !== 128'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pt: got %h want %h", ptOut(), 128'h0);
        end
        testsRun++;
        if (valid_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid: got %b want 0", valid_out);
        end
        testsRun++;
        if (busy_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy_out);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_fips_c1();
        int lat; bit tout, bdrop; logic [127:0] exp;
        applyStimulus(CT1, KEY1, PT1, 1'b1);
        waitForValid(1, lat, tout, bdrop);
        testsRun++;
        if (tout || lat != LATENCY) begin
            testsFailed++;
            $display("[TB] FAIL c1_latency: got %0d cycles (timeout=%0b) want %0d", lat, tout, LATENCY);
        end
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL c1_plaintext: got %h want %h", ptOut(), exp);
        end
        testsRun++;
        if (bdrop || busy_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL c1_busy: dropped_early=%0b busy_in_valid_cycle=%b want 0/0", bdrop, busy_out);
        end
        @(negedge CLK);
        testsRun++;
        if (valid_out !== 1'b0 || ptOut() !== PT1) begin
            testsFailed++;
            $display("[TB] FAIL c1_pulse_hold: valid=%b pt=%h want 0 and %h", valid_out, ptOut(), PT1);
        end
    endtask

    task automatic test_vector2();
        int lat; bit tout, bdrop; logic [127:0] exp;
        applyStimulus(CT2, KEY2, PT2, 1'b1);
        waitForValid(1, lat, tout, bdrop);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (tout || ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL v2_plaintext: got %h (timeout=%0b) want %h", ptOut(), tout, exp);
        end
        @(negedge CLK);
    endtask

    task automatic test_app_b();
        int lat; bit tout, bdrop; logic [127:0] exp;
        applyStimulus(CT3, KEY3, PT3, 1'b1);
        waitForValid(1, lat, tout, bdrop);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (tout || ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL appb_plaintext: got %h (timeout=%0b) want %h", ptOut(), tout, exp);
        end
        testsRun++;
        if (dut.rkQ[10] !== RK10) begin
            testsFailed++;
            $display("[TB] FAIL appb_rk10: got %h want %h", dut.rkQ[10], RK10);
        end
        @(negedge CLK);
    endtask

    task automatic test_ignored_start();
        int lat; bit tout, bdrop; int seenBefore; logic [127:0] exp;
        applyStimulus(CT1, KEY1, PT1, 1'b1);
        repeat (4) @(negedge CLK);
        applyStimulus(CT3, KEY3, PT3, 1'b0);
        waitForValid(6, lat, tout, bdrop);
        testsRun++;
        if (tout || lat != LATENCY) begin
            testsFailed++;
            $display("[TB] FAIL ignore_latency: got %0d cycles (timeout=%0b) want %0d", lat, tout, LATENCY);
        end
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL ignore_plaintext: got %h want %h", ptOut(), exp);
        end
        testsRun++;
        if (bdrop) begin
            testsFailed++;
            $display("[TB] FAIL ignore_busy: busy dropped before valid, want high throughout");
        end
        @(negedge CLK);
        seenBefore = validSeen;
        repeat (30) @(negedge CLK);
        testsRun++;
        if (validSeen != seenBefore || busy_out !== 1'b0 || ptOut() !== PT1) begin
            testsFailed++;
            $display("[TB] FAIL ignore_no_second: extra_valids=%0d busy=%b pt=%h want 0, 0, %h",
                     validSeen - seenBefore, busy_out, ptOut(), PT1);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit tout, bdrop; int seenBefore; logic [127:0] exp;
        applyStimulus(CT2, KEY2, PT2, 1'b1);
        repeat (15) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        expQ.delete();
        testsRun++;
        if (ptOut() !== 128'h0 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: pt=%h valid=%b busy=%b want all zero",
                     ptOut(), valid_out, busy_out);
        end
        seenBefore = validSeen;
        repeat (30) @(negedge CLK);
        testsRun++;
        if (validSeen != seenBefore) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_valid: got %0d valids want 0", validSeen - seenBefore);
        end
        applyStimulus(CT2, KEY2, PT2, 1'b1);
        waitForValid(1, lat, tout, bdrop);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (tout || lat != LATENCY || ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL midreset_restart: pt=%h lat=%0d timeout=%0b want %h lat %0d",
                     ptOut(), lat, tout, exp, LATENCY);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int lat; bit tout, bdrop; logic [127:0] exp;
        applyStimulus(CT1, KEY1, PT1, 1'b1);
        waitForValid(1, lat, tout, bdrop);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (tout || ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got %h (timeout=%0b) want %h", ptOut(), tout, exp);
        end
        applyStimulus(CT2, KEY2, PT2, 1'b1);
        testsRun++;
        if (valid_out !== 1'b0 || busy_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_accept: valid=%b busy=%b want 0 and 1", valid_out, busy_out);
        end
        waitForValid(1, lat, tout, bdrop);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
        testsRun++;
        if (tout || lat != LATENCY) begin
            testsFailed++;
            $display("[TB] FAIL b2b_latency: got %0d cycles (timeout=%0b) want %0d", lat, tout, LATENCY);
        end
        testsRun++;
        if (ptOut() !== exp) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got %h want %h", ptOut(), exp);
        end
        @(negedge CLK);
    endtask

    // Run every scenario in order, then report
    initial begin
        @(negedge CLK);
        test_reset();
        test_fips_c1();
        test_vector2();
        test_app_b();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
